// File: rtl/rtc_bus_secuenciador_if.sv
// Purpose: request side and RTC pad side of the multiplexed-bus sequencer.
// Latency: none; this file only bundles the signals.
// Backpressure: ocupado high means a new start is dropped, not queued.
interface rtc_bus_secuenciador_if #(
  parameter int W_AD = 8
);
  logic            fin_ciclo;
  logic            start;
  logic            rw;
  logic [W_AD-1:0] direccion;
  logic [W_AD-1:0] dato_wr;
  logic [W_AD-1:0] ad_in;
  logic [W_AD-1:0] ad_out;
  logic            ad_oe;
  logic            cs_n;
  logic            rd_n;
  logic            wr_n;
  logic            ad_sel;
  logic [W_AD-1:0] dato_rd;
  logic            ocupado;
  logic            listo;

  // Requester plus pad model: drives requests and slot ticks, observes the bus.
  modport master (
    output fin_ciclo, start, rw, direccion, dato_wr, ad_in,
    input  ad_out, ad_oe, cs_n, rd_n, wr_n, ad_sel, dato_rd, ocupado, listo
  );

  // Sequencer side.
  modport slave (
    input  fin_ciclo, start, rw, direccion, dato_wr, ad_in,
    output ad_out, ad_oe, cs_n, rd_n, wr_n, ad_sel, dato_rd, ocupado, listo
  );
endinterface

// File: rtl/rtc_bus_secuenciador.sv
// Purpose: one address+data transaction on the RTC multiplexed bus per start.
// Latency: 2*N_STROBE+4 slots plus 2 clks from start to listo; all outputs registered.
// Backpressure: start is dropped while a transaction is in flight; no fin_ciclo means no progress.
module rtc_bus_secuenciador #(
  parameter int W_AD     = 8,
  parameter int N_STROBE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  rtc_bus_secuenciador_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, DIR_SETUP, DIR_STROBE, DIR_HOLD, DAT_SETUP, DAT_STROBE, DAT_HOLD, FIN
  } estado_t;

  localparam logic [3:0] CNT_ULT = 4'(N_STROBE - 1);

  estado_t         estado, estado_sig;
  logic [3:0]      cnt, cnt_sig;
  logic            ultimo;
  logic            rw_q, rw_sig;
  logic [W_AD-1:0] dir_q, dir_sig;
  logic [W_AD-1:0] dw_q, dw_sig;
  logic [W_AD-1:0] dato_rd_sig;
  logic [W_AD-1:0] ad_out_sig;
  logic            ad_oe_sig, cs_n_sig, rd_n_sig, wr_n_sig, ad_sel_sig, ocupado_sig, listo_sig;

  // State, strobe slot counter and captured request; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado <= IDLE;
      cnt    <= '0;
      rw_q   <= 1'b0;
      dir_q  <= '0;
      dw_q   <= '0;
    end else begin
      estado <= estado_sig;
      cnt    <= cnt_sig;
      rw_q   <= rw_sig;
      dir_q  <= dir_sig;
      dw_q   <= dw_sig;
    end
  end

  // Next state, then the bus pattern of the state being entered so outputs line up with it.
  always_comb begin
    estado_sig  = estado;
    cnt_sig     = cnt;
    rw_sig      = rw_q;
    dir_sig     = dir_q;
    dw_sig      = dw_q;
    dato_rd_sig = bus.dato_rd;
    ultimo      = (cnt == CNT_ULT);

    case (estado)
      IDLE: begin
        // fin_ciclo is irrelevant here; a start always wins.
        if (bus.start) begin
          estado_sig = DIR_SETUP;
          rw_sig     = bus.rw;
          dir_sig    = bus.direccion;
          dw_sig     = bus.dato_wr;
        end
      end
      DIR_SETUP:  if (bus.fin_ciclo) estado_sig = DIR_STROBE;
      DIR_STROBE: begin
        if (bus.fin_ciclo) begin
          if (ultimo) estado_sig = DIR_HOLD;
          else        cnt_sig    = cnt + 4'd1;
        end
      end
      DIR_HOLD:   if (bus.fin_ciclo) estado_sig = DAT_SETUP;
      DAT_SETUP:  if (bus.fin_ciclo) estado_sig = DAT_STROBE;
      DAT_STROBE: begin
        if (bus.fin_ciclo) begin
          if (ultimo) begin
            estado_sig = DAT_HOLD;
            // Sample the pad at the very end of the read strobe.
            if (rw_q) dato_rd_sig = bus.ad_in;
          end else begin
            cnt_sig = cnt + 4'd1;
          end
        end
      end
      DAT_HOLD:   if (bus.fin_ciclo) estado_sig = FIN;
      FIN:        estado_sig = IDLE;
      default:    estado_sig = IDLE;
    endcase

    // Every state change restarts the slot count, so each strobe state begins at zero.
    if (estado_sig != estado) cnt_sig = '0;

    ad_out_sig  = '0;
    ad_oe_sig   = 1'b0;
    cs_n_sig    = 1'b1;
    rd_n_sig    = 1'b1;
    wr_n_sig    = 1'b1;
    ad_sel_sig  = 1'b0;
    ocupado_sig = 1'b0;
    listo_sig   = 1'b0;

    case (estado_sig)
      DIR_SETUP, DIR_STROBE, DIR_HOLD: begin
        cs_n_sig    = 1'b0;
        ocupado_sig = 1'b1;
        ad_oe_sig   = 1'b1;
        ad_out_sig  = dir_sig;
        // The address is always latched by the chip with a write strobe.
        wr_n_sig    = (estado_sig != DIR_STROBE);
      end
      DAT_SETUP, DAT_STROBE, DAT_HOLD: begin
        cs_n_sig    = 1'b0;
        ocupado_sig = 1'b1;
        ad_sel_sig  = 1'b1;
        if (rw_sig) begin
          // Release the bus for the whole read data phase so the chip can drive it.
          rd_n_sig = (estado_sig != DAT_STROBE);
        end else begin
          ad_oe_sig  = 1'b1;
          ad_out_sig = dw_sig;
          wr_n_sig   = (estado_sig != DAT_STROBE);
        end
      end
      FIN:     listo_sig = 1'b1;
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.ad_out  <= '0;
      bus.ad_oe   <= 1'b0;
      bus.cs_n    <= 1'b1;
      bus.rd_n    <= 1'b1;
      bus.wr_n    <= 1'b1;
      bus.ad_sel  <= 1'b0;
      bus.dato_rd <= '0;
      bus.ocupado <= 1'b0;
      bus.listo   <= 1'b0;
    end else begin
      bus.ad_out  <= ad_out_sig;
      bus.ad_oe   <= ad_oe_sig;
      bus.cs_n    <= cs_n_sig;
      bus.rd_n    <= rd_n_sig;
      bus.wr_n    <= wr_n_sig;
      bus.ad_sel  <= ad_sel_sig;
      bus.dato_rd <= dato_rd_sig;
      bus.ocupado <= ocupado_sig;
      bus.listo   <= listo_sig;
    end
  end

endmodule

// File: tb/tb_rtc_bus_secuenciador.sv
// Purpose: self-checking bench for rtc_bus_secuenciador (N_STROBE=2, W_AD=8).
// Latency: expects listo (2*N_STROBE+4) slots after the start clock.
// Backpressure: exercises dropped starts, mid-transaction reset and stalled slots.
module tb_rtc_bus_secuenciador;

  localparam int W  = 8;
  localparam int NS = 2;
  localparam int NSLOT = 2 * NS + 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  rtc_bus_secuenciador_if #(.W_AD(W)) bus ();

  rtc_bus_secuenciador #(.W_AD(W), .N_STROBE(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int n_listo = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model: slot index within the transaction ----------------
  bit          m_act = 1'b0;
  bit          m_fin = 1'b0;
  int          m_k   = 0;
  bit          m_rw  = 1'b0;
  logic [W-1:0] m_dir = '0, m_dw = '0, m_rd = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_act = 1'b0; m_fin = 1'b0; m_k = 0; m_rd = '0;
    end else if (m_fin) begin
      m_fin = 1'b0;
    end else if (!m_act) begin
      if (bus.start) begin
        m_act = 1'b1; m_k = 0;
        m_rw = bus.rw; m_dir = bus.direccion; m_dw = bus.dato_wr;
      end
    end else if (bus.fin_ciclo) begin
      // The last data strobe slot is slot 2*NS+2.
      if (m_rw && m_k == 2 * NS + 2) m_rd = bus.ad_in;
      m_k++;
      if (m_k == NSLOT) begin
        m_act = 1'b0; m_fin = 1'b1;
      end
    end
  end

  function automatic logic [22:0] expected();
    logic cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, sel = 1'b0, oe = 1'b0, ocup = 1'b0, lst = 1'b0;
    logic [W-1:0] o = '0;
    bit strobe;
    if (m_fin) begin
      lst = 1'b1;
    end else if (m_act) begin
      cs_n = 1'b0; ocup = 1'b1;
      if (m_k <= NS + 1) begin
        oe = 1'b1; o = m_dir;
        if (m_k >= 1 && m_k <= NS) wr_n = 1'b0;
      end else begin
        sel = 1'b1;
        strobe = (m_k >= NS + 3) && (m_k <= 2 * NS + 2);
        if (m_rw) begin
          if (strobe) rd_n = 1'b0;
        end else begin
          oe = 1'b1; o = m_dw;
          if (strobe) wr_n = 1'b0;
        end
      end
    end
    return {cs_n, rd_n, wr_n, sel, oe, o, m_rd, ocup, lst};
  endfunction

  // Whole-bus comparison every clock, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("outputs", {9'd0, bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_sel, bus.ad_oe, bus.ad_out,
                      bus.dato_rd, bus.ocupado, bus.listo}, {9'd0, expected()});
      if (bus.listo) n_listo++;
    end
  end

  // ---------------- transaction table ----------------
  typedef struct {
    bit           rw;
    logic [W-1:0] dir, dw, adin;
    int           per;        // fin_ciclo period in clks
    int           inj;        // clk of an extra start pulse (0 = none)
    int           rst_at;     // clk with reset low (0 = none)
    int           stall_at;   // first clk of a fin_ciclo stall
    int           stall_len;
    int           exp_cyc;    // clks from start edge to listo (-1 = never)
    int           exp_listo;
    logic [W-1:0] exp_rd;
  } vec_t;

  vec_t tv[9];

  initial begin
    tv[0] = '{1'b0, 8'h21, 8'h45, 8'h00, 6, 0,  0,  0,  0, 48, 1, 8'h00};
    tv[1] = '{1'b1, 8'h22, 8'h00, 8'h37, 6, 0,  0,  0,  0, 48, 1, 8'h37};
    tv[2] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1, 0,  0,  0,  0,  8, 1, 8'h37};
    tv[3] = '{1'b1, 8'h7E, 8'h00, 8'hC3, 3, 16, 0,  0,  0, 24, 1, 8'hC3};
    tv[4] = '{1'b0, 8'h33, 8'h44, 8'h00, 2, 0,  0,  0,  0, 16, 1, 8'hC3};
    tv[5] = '{1'b0, 8'h10, 8'h20, 8'h00, 6, 0,  13, 0,  0, -1, 0, 8'h00};
    tv[6] = '{1'b0, 8'h55, 8'h66, 8'h00, 6, 0,  0,  0,  0, 48, 1, 8'h00};
    tv[7] = '{1'b1, 8'h0F, 8'h00, 8'h9C, 6, 0,  0,  20, 50, 98, 1, 8'h9C};
    tv[8] = '{1'b0, 8'hC0, 8'hDE, 8'h00, 1, 0,  0,  3,  50, 58, 1, 8'h9C};
  end

  initial begin
    int first, nl, ph, win;
    bus.fin_ciclo = 1'b0; bus.start = 1'b0; bus.rw = 1'b0;
    bus.direccion = '0; bus.dato_wr = '0; bus.ad_in = '0;

    // Reset held for 10 clks with fin_ciclo toggling.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.fin_ciclo = i[0];
      bus.start = (i == 4);
      tick();
      chk_en = 1'b1;
      cmp("reset_state", {bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, bus.ocupado, bus.listo, bus.dato_rd},
          {6'b111000, 8'h00});
    end
    bus.start = 1'b0; bus.fin_ciclo = 1'b0;
    reset = 1'b1;
    tick();

    for (int t = 0; t < 9; t++) begin
      bus.start = 1'b1; bus.rw = tv[t].rw; bus.direccion = tv[t].dir;
      bus.dato_wr = tv[t].dw; bus.ad_in = tv[t].adin; bus.fin_ciclo = 1'b0;
      tick();
      bus.start = 1'b0;
      first = -1; nl = 0; ph = 0;
      win = NSLOT * tv[t].per + tv[t].stall_len + 6;
      for (int j = 1; j <= win; j++) begin
        bus.start = (j == tv[t].inj);
        if (j == tv[t].inj) begin
          bus.rw = ~tv[t].rw; bus.direccion = 8'hEE; bus.dato_wr = 8'h99;
        end
        reset = (j != tv[t].rst_at);
        if (j >= tv[t].stall_at && j < tv[t].stall_at + tv[t].stall_len) begin
          bus.fin_ciclo = 1'b0;
        end else begin
          ph++;
          bus.fin_ciclo = (ph % tv[t].per == 0);
        end
        tick();
        if (bus.listo) begin
          nl++;
          if (first < 0) first = j;
        end
        if (j == tv[t].rst_at)
          cmp("abort_idle", {26'd0, bus.cs_n, bus.rd_n, bus.wr_n, bus.ad_oe, bus.ocupado, bus.listo},
              {26'd0, 6'b111000});
      end
      bus.start = 1'b0; bus.fin_ciclo = 1'b0; reset = 1'b1;
      cmp($sformatf("listo_clk[%0d]", t), first, tv[t].exp_cyc);
      cmp($sformatf("listo_count[%0d]", t), nl, tv[t].exp_listo);
      cmp($sformatf("dato_rd[%0d]", t), {24'd0, bus.dato_rd}, {24'd0, tv[t].exp_rd});
      tick();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 399) != 0);
      bus.fin_ciclo = ($urandom_range(0, 3) == 0);
      bus.start = ($urandom_range(0, 5) == 0);
      bus.rw = 1'($urandom);
      bus.direccion = 8'($urandom);
      bus.dato_wr = 8'($urandom);
      bus.ad_in = 8'($urandom);
      tick();
    end
    reset = 1'b1; bus.start = 1'b0; bus.fin_ciclo = 1'b0;
    tick();
    cmp("random_listos_seen", {31'd0, n_listo > 10}, 32'd1);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_bus_secuenciador.md
Name: rtc_bus_secuenciador

Overview:
Downstream consumer of the RTC cycle/duration counter stage. Runs one multiplexed-bus transaction to the external RTC chip per request: an address phase, then a data phase. Drives cs_n, rd_n, wr_n, ad_sel and the AD bus enable. Each phase is timed in slots; one slot equals one fin_ciclo pulse from the cycle counter stage.

Parameters:
W_AD, 8, width of multiplexed address/data bus
N_STROBE, 2, slots rd_n/wr_n stay low in each strobe state (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
fin_ciclo  in  1  one-clk pulse, end of one timing slot (from cycle counter stage)
start  in  1  one-clk request; sampled only in IDLE
rw  in  1  1 = read, 0 = write; captured with start
direccion  in  W_AD  register address; captured with start
dato_wr  in  W_AD  write data; captured with start
ad_in  in  W_AD  AD bus value read from pad
ad_out  out  W_AD  AD bus drive value
ad_oe  out  1  1 = block drives AD bus
cs_n  out  1  RTC chip select, active low
rd_n  out  1  RTC read strobe, active low
wr_n  out  1  RTC write strobe, active low
ad_sel  out  1  0 = address phase, 1 = data phase
dato_rd  out  W_AD  last read data; holds until next read completes
ocupado  out  1  transaction in progress
listo  out  1  one-clk pulse, transaction complete

Behaviour:
- Reset (reset==0 at posedge): state IDLE; cs_n=rd_n=wr_n=1; ad_sel=0; ad_oe=0; ad_out=0; dato_rd=0; ocupado=0; listo=0; slot counter=0. Reset mid-transaction aborts immediately. No listo pulse on abort.
- All outputs are registered. State advances only on clocks where fin_ciclo=1, except in IDLE and FIN.
- IDLE: if start=1, capture rw/direccion/dato_wr, set ocupado=1, and go to DIR_SETUP on the next clk, independent of fin_ciclo.
- DIR_SETUP (1 slot): cs_n=0, ad_sel=0, ad_oe=1, ad_out=direccion.
- DIR_STROBE (N_STROBE slots): as DIR_SETUP plus wr_n=0. Address is always written.
- DIR_HOLD (1 slot): wr_n=1; ad_out still holds direccion.
- DAT_SETUP (1 slot): ad_sel=1.
  - Write: ad_oe=1, ad_out=dato_wr.
  - Read: ad_oe=0.
- DAT_STROBE (N_STROBE slots): rd_n=0 if read, else wr_n=0.
  - Read: on the clk where the final fin_ciclo of this state is seen, dato_rd <= ad_in.
- DAT_HOLD (1 slot): strobes high. Write keeps driving dato_wr.
- FIN (1 clk): cs_n=1, ad_oe=0, ad_sel=0, listo=1, ocupado=0. Next clk: IDLE.
- Strobe slot counter: 4 bits. Reset to 0 on entry to each strobe state; increments on fin_ciclo; exits when count==N_STROBE-1 and fin_ciclo=1.
- start while ocupado=1 is ignored; it is not queued.
- start and fin_ciclo both high in IDLE: start is accepted; fin_ciclo is ignored.
- Transaction length: 2*N_STROBE+4 slots + 2 clks (IDLE->DIR_SETUP and FIN).
- Never: rd_n and wr_n low in the same clk; ad_oe=1 while rd_n=0; cs_n=1 while any strobe is low.
- fin_ciclo stuck at 0: block waits in the current state indefinitely. No timeout.

Test Plan:
1. reset=0 for 10 clks, fin_ciclo toggling -> cs_n=rd_n=wr_n=1, ad_oe=0, ocupado=0, dato_rd=0 throughout.
2. Write: N_STROBE=2, fin_ciclo every 6 clks, start with rw=0, direccion=8'h21, dato_wr=8'h45 ->
   - ad_out=21 with ad_sel=0 and wr_n low for exactly 2 slots.
   - Then ad_out=45 with ad_sel=1 and wr_n low for 2 slots.
   - listo one clk after 8 slots; rd_n never low.
3. Read: rw=1, direccion=8'h22, ad_in=8'h37 during DAT_STROBE -> ad_oe=0 while rd_n low for 2 slots, dato_rd=37 by listo, dato_rd holds 37 afterwards.
4. Second start pulse issued during DAT_STROBE -> ignored; exactly one listo; next start after listo is accepted normally.
5. reset=0 asserted in DIR_STROBE -> next clk all strobes high, cs_n=1, ad_oe=0, ocupado=0, no listo. Fresh write after release completes correctly.
6. fin_ciclo held 0 for 50 clks mid-transaction -> outputs frozen in the current state; resuming fin_ciclo completes the transaction with correct timing.
